sme_loader: RTL and testbench

SME_LOADER -- requirements
Module: sme_loader

---
 rtl/sme_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_sme_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_loader.sv
// sme_loader: buffers framed string/pattern records into a 32-entry FIFO and
// replays each complete record to the SME as a contiguous burst of character
// strobes, then captures the SME result after every pattern record.
// Optional feature macro SME_LOADER_STATS_EN adds saturating pattern/hit counters.
module sme_loader (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [7:0] in_data_i,
   input  logic       in_kind_i,
   input  logic       in_eop_i,
   output logic [7:0] chardata_o,
   output logic       isstring_o,
   output logic       ispattern_o,
   input  logic       sme_valid_i,
   input  logic       sme_match_i,
   input  logic [4:0] sme_match_index_i,
   output logic       res_valid_o,
   output logic       res_match_o,
   output logic [4:0] res_index_o,
   output logic       err_len_o
`ifdef SME_LOADER_STATS_EN
   ,
   output logic [15:0] pat_cnt_o,
   output logic [15:0] hit_cnt_o
`endif
);

   typedef enum logic [1:0] {StIdle, StSend, StGap, StWait} state_e;

   // FIFO storage, entry = {kind, eop, data}
   logic [9:0] mem_q [32];
   logic [4:0] wr_ptr_q, rd_ptr_q;
   logic [5:0] cnt_q, cnt_d;
   logic [5:0] rec_cnt_q, rec_cnt_d;

   // Write-side record tracking
   logic [5:0] len_q, len_d;
   logic       kind_q, kind_d;
   logic       discard_q, discard_d;
   logic       err_q, err_d;

   state_e     state_q, state_d;

   logic [7:0] chardata_q, chardata_d;
   logic       isstring_q, isstring_d;
   logic       ispattern_q, ispattern_d;
   logic       res_valid_q, res_valid_d;
   logic       res_match_q, res_match_d;
   logic [4:0] res_index_q, res_index_d;

   logic       full, accept, push, pop, pop_eop, wr_rec;
   logic       cur_kind, at_limit, wr_eop;
   logic [5:0] limit, len_inc;
   logic [9:0] wr_entry, rd_entry;

   assign full       = (cnt_q == 6'd32);
   assign in_ready_o = !full && !reset_i;
   assign accept     = in_valid_i && in_ready_o;

   // Kind is taken from the first beat of a record and held for the rest.
   assign cur_kind = (len_q == 6'd0) ? in_kind_i : kind_q;
   assign limit    = cur_kind ? 6'd8 : 6'd32;
   assign len_inc  = len_q + 6'd1;
   assign at_limit = (len_inc == limit);
   assign push     = accept && !discard_q;
   assign wr_eop   = in_eop_i || at_limit;
   assign wr_entry = {cur_kind, wr_eop, in_data_i};
   assign wr_rec   = push && wr_eop;

   assign rd_entry = mem_q[rd_ptr_q];
   assign pop      = (state_q == StSend);
   assign pop_eop  = pop && rd_entry[8];

   // Write-side length/discard tracking and truncation flag
   always_comb begin
      len_d     = len_q;
      kind_d    = kind_q;
      discard_d = discard_q;
      err_d     = err_q;
      if (accept) begin
         if (discard_q) begin
            // Swallow the tail of a truncated record up to its real eop.
            if (in_eop_i) discard_d = 1'b0;
         end else begin
            kind_d = cur_kind;
            if (in_eop_i) begin
               len_d = 6'd0;
            end else if (at_limit) begin
               len_d     = 6'd0;
               discard_d = 1'b1;
               err_d     = 1'b1;
            end else begin
               len_d = len_inc;
            end
         end
      end
   end

   // FIFO occupancy and complete-record count
   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 6'd1;
         2'b01:   cnt_d = cnt_q - 6'd1;
         default: cnt_d = cnt_q;
      endcase
      rec_cnt_d = rec_cnt_q;
      unique case ({wr_rec, pop_eop})
         2'b10:   rec_cnt_d = rec_cnt_q + 6'd1;
         2'b01:   rec_cnt_d = rec_cnt_q - 6'd1;
         default: rec_cnt_d = rec_cnt_q;
      endcase
   end

   // Read FSM next state and registered SME-facing outputs
   always_comb begin
      state_d     = state_q;
      chardata_d  = chardata_q;
      isstring_d  = 1'b0;
      ispattern_d = 1'b0;
      res_valid_d = 1'b0;
      res_match_d = res_match_q;
      res_index_d = res_index_q;
      unique case (state_q)
         StIdle: begin
            if (rec_cnt_q != 6'd0) state_d = StSend;
         end
         StSend: begin
            chardata_d  = rd_entry[7:0];
            isstring_d  = !rd_entry[9];
            ispattern_d = rd_entry[9];
            if (rd_entry[8]) state_d = rd_entry[9] ? StWait : StGap;
         end
         StGap: begin
            // The last strobe is still on the outputs this cycle, so the
            // next record can be popped now and still leave one low cycle.
            state_d = (rec_cnt_q != 6'd0) ? StSend : StIdle;
         end
         StWait: begin
            if (sme_valid_i) begin
               res_valid_d = 1'b1;
               res_match_d = sme_match_i;
               res_index_d = sme_match_index_i;
               state_d     = StGap;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO storage, no reset needed since pointers gate its use
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q    <= 5'd0;
         rd_ptr_q    <= 5'd0;
         cnt_q       <= 6'd0;
         rec_cnt_q   <= 6'd0;
         len_q       <= 6'd0;
         kind_q      <= 1'b0;
         discard_q   <= 1'b0;
         err_q       <= 1'b0;
         state_q     <= StIdle;
         chardata_q  <= 8'd0;
         isstring_q  <= 1'b0;
         ispattern_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_match_q <= 1'b0;
         res_index_q <= 5'd0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 5'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 5'd1;
         cnt_q       <= cnt_d;
         rec_cnt_q   <= rec_cnt_d;
         len_q       <= len_d;
         kind_q      <= kind_d;
         discard_q   <= discard_d;
         err_q       <= err_d;
         state_q     <= state_d;
         chardata_q  <= chardata_d;
         isstring_q  <= isstring_d;
         ispattern_q <= ispattern_d;
         res_valid_q <= res_valid_d;
         res_match_q <= res_match_d;
         res_index_q <= res_index_d;
      end
   end

   assign chardata_o  = chardata_q;
   assign isstring_o  = isstring_q;
   assign ispattern_o = ispattern_q;
   assign res_valid_o = res_valid_q;
   assign res_match_o = res_match_q;
   assign res_index_o = res_index_q;
   assign err_len_o   = err_q;

`ifdef SME_LOADER_STATS_EN
   logic [15:0] pat_cnt_q, hit_cnt_q;

   // Saturating result counters
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pat_cnt_q <= 16'd0;
         hit_cnt_q <= 16'd0;
      end else if (res_valid_q) begin
         if (pat_cnt_q != 16'hFFFF) pat_cnt_q <= pat_cnt_q + 16'd1;
         if (res_match_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
      end
   end

   assign pat_cnt_o = pat_cnt_q;
   assign hit_cnt_o = hit_cnt_q;
`endif

endmodule

// File: tb/tb_sme_loader.sv
// tb_sme_loader: drives framed records into sme_loader and checks the strobe
// stream, record gaps, SME results and err_len against a record-level model.
module tb_sme_loader;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_ready, in_kind, in_eop;
   logic [7:0] in_data, chardata;
   logic       isstring, ispattern;
   logic       sme_valid, sme_match;
   logic [4:0] sme_idx, res_index;
   logic       res_valid, res_match, err_len;
`ifdef SME_LOADER_STATS_EN
   logic [15:0] pat_cnt, hit_cnt;
`endif

   always #5 clk = ~clk;

   sme_loader dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .in_valid_i        (in_valid),
      .in_ready_o        (in_ready),
      .in_data_i         (in_data),
      .in_kind_i         (in_kind),
      .in_eop_i          (in_eop),
      .chardata_o        (chardata),
      .isstring_o        (isstring),
      .ispattern_o       (ispattern),
      .sme_valid_i       (sme_valid),
      .sme_match_i       (sme_match),
      .sme_match_index_i (sme_idx),
      .res_valid_o       (res_valid),
      .res_match_o       (res_match),
      .res_index_o       (res_index),
      .err_len_o         (err_len)
`ifdef SME_LOADER_STATS_EN
      ,
      .pat_cnt_o         (pat_cnt),
      .hit_cnt_o         (hit_cnt)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model state: expected strobes {last, kind, char}, expected results {match, index}
   logic [9:0] exp_q [$];
   logic [5:0] exp_res [$];
   int         gaps_q [$];
   bit         exp_err = 0;
   int         exp_pat = 0, exp_hit = 0;
   int         pend_cnt = 0;
   bit         hold_sme = 0, fix_resp = 0;
   bit         at_start = 1, have_prev = 0;
   int         low_run = 0, strobe_cnt = 0;
   logic [7:0] recbuf [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Strobe / result monitor
   always @(negedge clk) begin
      logic [9:0] e;
      logic [5:0] r;
      if (isstring || ispattern) begin
         if (exp_q.size() == 0) begin
            chk("unexp_strobe", {22'd0, isstring, ispattern, chardata}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("strobe", {22'd0, isstring, ispattern, chardata}, {22'd0, !e[8], e[8], e[7:0]});
            if (at_start && have_prev) begin
               chk("gap_min", {31'd0, low_run >= 1}, 32'd1);
               gaps_q.push_back(low_run);
            end
            at_start  = e[9];
            have_prev = 1;
            if (e[9] && e[8]) pend_cnt++;
         end
         low_run = 0;
         strobe_cnt++;
      end else begin
         low_run++;
      end
      if (res_valid) begin
         if (exp_res.size() == 0) begin
            chk("unexp_res", {26'd0, res_match, res_index}, 32'hFFFF);
         end else begin
            r = exp_res.pop_front();
            chk("res", {26'd0, res_match, res_index}, {26'd0, r});
         end
      end
   end

   // SME responder: answers each emitted pattern after a random delay
   initial begin
      logic       m;
      logic [4:0] ix;
      sme_valid = 0; sme_match = 0; sme_idx = 0;
      forever begin
         @(negedge clk);
         sme_valid = 0;
         if (pend_cnt > 0 && !hold_sme && (fix_resp || $urandom_range(0, 2) == 0)) begin
            m  = fix_resp ? 1'b1 : 1'($urandom);
            ix = fix_resp ? 5'd1 : 5'($urandom);
            sme_valid = 1; sme_match = m; sme_idx = ix;
            exp_res.push_back({m, ix});
            exp_pat++;
            if (m) exp_hit++;
            pend_cnt--;
         end
      end
   end

   // Offer one beat (called at negedge) until accepted
   task automatic beat(input logic [7:0] d, input logic k, input logic e);
      int  n = 0;
      bit  ok = 0;
      in_valid = 1; in_data = d; in_kind = k; in_eop = e;
      while (!ok && n < 300) begin
         #1 ok = in_ready;
         @(negedge clk);
         n++;
      end
      in_valid = 0;
      if (!ok) chk("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_record(input logic k, input int n, input bit rnd_idle);
      int lim = k ? 8 : 32;
      int m = (n < lim) ? n : lim;
      for (int i = 0; i < m; i++) exp_q.push_back({(i == m - 1), k, recbuf[i]});
      if (n > lim) exp_err = 1;
      for (int i = 0; i < n; i++) begin
         // Kind on non-first beats must be ignored.
         beat(recbuf[i], (i == 0) ? k : 1'($urandom), i == n - 1);
         if (rnd_idle) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic fill_buf(input int n);
      for (int i = 0; i < n; i++) recbuf[i] = 8'($urandom_range(8'h61, 8'h7a));
   endtask

   task automatic do_reset(input int n);
      reset = 1; in_valid = 0;
      exp_q.delete(); exp_res.delete(); gaps_q.delete();
      pend_cnt = 0; exp_err = 0; exp_pat = 0; exp_hit = 0;
      at_start = 1; have_prev = 0;
      @(negedge clk);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_outs", {15'd0, chardata, isstring, ispattern, res_valid, res_match, res_index,
                       err_len}, 32'd0);
      repeat (n - 1) @(negedge clk);
      reset = 0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || pend_cnt != 0 || exp_res.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", {31'd0, n < 3000}, 32'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int acc, n, s0;
      reset = 1; in_valid = 0; in_data = 0; in_kind = 0; in_eop = 0;
      @(negedge clk);
      do_reset(3);

      // "ab" string then "b" pattern, fixed result match=1 index=1
      fix_resp = 1;
      recbuf[0] = 8'h61; recbuf[1] = 8'h62;
      send_record(1'b0, 2, 0);
      recbuf[0] = 8'h62;
      send_record(1'b1, 1, 0);
      wait_drain();
      chk("ab_gap", (gaps_q.size() >= 1) ? gaps_q[0] : 99, 32'd1);
      chk("ab_err", {31'd0, err_len}, 32'd0);
      fix_resp = 0;

      // 40-char string truncated to 32, then a short string
      fill_buf(40);
      send_record(1'b0, 40, 0);
      fill_buf(3);
      send_record(1'b0, 3, 1);
      wait_drain();
      chk("str40_err", {31'd0, err_len}, 32'd1);

      // 10-char pattern truncated to 8
      do_reset(2);
      fill_buf(10);
      send_record(1'b1, 10, 0);
      wait_drain();
      chk("pat10_err", {31'd0, err_len}, 32'd1);

      // Stall in WAIT while a 40-beat string is offered
      do_reset(1);
      hold_sme = 1;
      fill_buf(3);
      send_record(1'b1, 3, 0);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      fill_buf(40);
      for (int i = 0; i < 32; i++) exp_q.push_back({(i == 31), 1'b0, recbuf[i]});
      exp_err = 1;
      s0 = strobe_cnt;
      acc = 0;
      for (int c = 0; c < 50; c++) begin
         in_valid = 1; in_data = recbuf[acc]; in_kind = (acc == 0) ? 1'b0 : 1'($urandom);
         in_eop = (acc == 39);
         #1 if (in_ready) acc++;
         @(negedge clk);
      end
      chk("stall_acc", acc, 32'd32);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_strobes", strobe_cnt - s0, 32'd0);
      hold_sme = 0;
      n = 0;
      while (acc < 40 && n < 500) begin
         in_valid = 1; in_data = recbuf[acc]; in_eop = (acc == 39);
         #1 if (in_ready) acc++;
         @(negedge clk);
         n++;
      end
      in_valid = 0;
      chk("stall_rest", acc, 32'd40);
      wait_drain();
      chk("stall_err", {31'd0, err_len}, 32'd1);

      // Reset mid-string, then "x"
      do_reset(1);
      fill_buf(10);
      for (int i = 0; i < 5; i++) beat(recbuf[i], 1'b0, 1'b0);
      do_reset(1);
      s0 = strobe_cnt;
      recbuf[0] = 8'h78;
      send_record(1'b0, 1, 0);
      wait_drain();
      chk("x_count", strobe_cnt - s0, 32'd1);

      // Randomized records
      do_reset(2);
      for (int r = 0; r < 25; r++) begin
         n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(30, 40))
                                         : int'($urandom_range(1, 12));
         fill_buf(n);
         send_record(1'($urandom), n, 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();
      chk("rand_err", {31'd0, err_len}, {31'd0, exp_err});
`ifdef SME_LOADER_STATS_EN
      chk("pat_cnt", {16'd0, pat_cnt}, exp_pat);
      chk("hit_cnt", {16'd0, hit_cnt}, exp_hit);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
